secuenciador_cs_registros: RTL and testbench



---
 rtl/secuenciador_cs_registros.sv | 142 ++++++++++++++
 tb/tb_secuenciador_cs_registros.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/secuenciador_cs_registros.sv
// rtl/secuenciador_cs_registros.sv - register-group chip-select sequencer for the RTC configuration bus
module secuenciador_cs_registros #(
    parameter int N_HORA   = 3,
    parameter int N_FECHA  = 4,
    parameter int N_TIMER  = 3,
    parameter bit MODO_SEC = 1'b1,
    parameter int TIMEOUT  = 255,
    localparam int N_TOTAL = N_HORA + N_FECHA + N_TIMER,
    localparam int N_MAX   = (N_HORA > N_FECHA) ? ((N_HORA > N_TIMER) ? N_HORA : N_TIMER)
                                                : ((N_FECHA > N_TIMER) ? N_FECHA : N_TIMER),
    localparam int IW      = (N_MAX > 1) ? $clog2(N_MAX) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         funcion_conf,
    input  logic               inicio,
    input  logic               listo,
    output logic [N_TOTAL-1:0] cs,
    output logic [IW-1:0]      indice,
    output logic               ocupado,
    output logic               fin,
    output logic               error
);

    localparam int BW = $clog2(N_TOTAL + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [N_TOTAL-1:0] CS_UNO     = N_TOTAL'(1);
    localparam logic [N_TOTAL-1:0] MASK_HORA  = {N_TOTAL{1'b1}} >> (N_TOTAL - N_HORA);
    localparam logic [N_TOTAL-1:0] MASK_FECHA = ({N_TOTAL{1'b1}} >> (N_TOTAL - N_FECHA)) << N_HORA;
    localparam logic [N_TOTAL-1:0] MASK_TIMER = ({N_TOTAL{1'b1}} >> (N_TOTAL - N_TIMER)) << (N_HORA + N_FECHA);

    typedef enum logic [1:0] {IDLE, ACTIVO, PAUSA, FIN} estado_t;

    estado_t            estado;
    logic [BW-1:0]      base_q;
    logic [IW-1:0]      ultimo_q;
    logic [TW-1:0]      cnt;
    logic [IW-1:0]      indice_sig;
    logic [N_TOTAL-1:0] mascara_conf;

    assign indice_sig = indice + IW'(1);

    always_comb begin
        mascara_conf = '0;
        case (funcion_conf)
            3'b001:  mascara_conf = MASK_HORA;
            3'b010:  mascara_conf = MASK_FECHA;
            3'b100:  mascara_conf = MASK_TIMER;
            default: mascara_conf = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado   <= IDLE;
            cs       <= '0;
            indice   <= '0;
            ocupado  <= 1'b0;
            fin      <= 1'b0;
            error    <= 1'b0;
            cnt      <= '0;
            base_q   <= '0;
            ultimo_q <= '0;
        end else if (!MODO_SEC) begin
            // Legacy users get the whole group decoded every cycle.
            cs <= mascara_conf;
        end else begin
            fin   <= 1'b0;
            error <= 1'b0;
            case (estado)
                IDLE: begin
                    cs      <= '0;
                    indice  <= '0;
                    ocupado <= 1'b0;
                    cnt     <= '0;
                    if (inicio) begin
                        case (funcion_conf)
                            3'b001: begin
                                base_q   <= '0;
                                ultimo_q <= IW'(N_HORA - 1);
                                cs       <= CS_UNO;
                                ocupado  <= 1'b1;
                                estado   <= ACTIVO;
                            end
                            3'b010: begin
                                base_q   <= BW'(N_HORA);
                                ultimo_q <= IW'(N_FECHA - 1);
                                cs       <= CS_UNO << N_HORA;
                                ocupado  <= 1'b1;
                                estado   <= ACTIVO;
                            end
                            3'b100: begin
                                base_q   <= BW'(N_HORA + N_FECHA);
                                ultimo_q <= IW'(N_TIMER - 1);
                                cs       <= CS_UNO << (N_HORA + N_FECHA);
                                ocupado  <= 1'b1;
                                estado   <= ACTIVO;
                            end
                            default: error <= 1'b1;
                        endcase
                    end
                end
                ACTIVO: begin
                    // listo takes priority over an expiring counter.
                    if (listo) begin
                        cs  <= '0;
                        cnt <= '0;
                        if (indice == ultimo_q) begin
                            fin    <= 1'b1;
                            estado <= FIN;
                        end else begin
                            estado <= PAUSA;
                        end
                    end else if (cnt == TW'(TIMEOUT - 1)) begin
                        cs      <= '0;
                        cnt     <= '0;
                        error   <= 1'b1;
                        ocupado <= 1'b0;
                        indice  <= '0;
                        estado  <= IDLE;
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
                PAUSA: begin
                    cnt    <= '0;
                    indice <= indice_sig;
                    cs     <= CS_UNO << (base_q + BW'(indice_sig));
                    estado <= ACTIVO;
                end
                FIN: begin
                    cs      <= '0;
                    indice  <= '0;
                    ocupado <= 1'b0;
                    estado  <= IDLE;
                end
                default: estado <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_secuenciador_cs_registros.sv
// tb/tb_secuenciador_cs_registros.sv - scoreboard bench for sequential and legacy chip-select modes
module tb_secuenciador_cs_registros;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] funcion_conf = 3'b000;
    logic       inicio = 1'b0;
    logic       listo = 1'b0;

    logic [9:0] cs_s, cs_l;
    logic [1:0] indice_s, indice_l;
    logic       ocupado_s, ocupado_l, fin_s, fin_l, error_s, error_l;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [9:0] cs;
        logic [1:0] indice;
        logic       ocupado;
        logic       fin;
        logic       error;
        logic [9:0] cs_leg;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    secuenciador_cs_registros #(.MODO_SEC(1'b1), .TIMEOUT(8)) dut_seq (
        .clk(clk), .reset_n(reset_n), .funcion_conf(funcion_conf), .inicio(inicio), .listo(listo),
        .cs(cs_s), .indice(indice_s), .ocupado(ocupado_s), .fin(fin_s), .error(error_s)
    );

    secuenciador_cs_registros #(.MODO_SEC(1'b0)) dut_leg (
        .clk(clk), .reset_n(reset_n), .funcion_conf(funcion_conf), .inicio(inicio), .listo(listo),
        .cs(cs_l), .indice(indice_l), .ocupado(ocupado_l), .fin(fin_l), .error(error_l)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [9:0] leg_mask(input logic [2:0] conf);
        case (conf)
            3'b001:  return 10'h007;
            3'b010:  return 10'h078;
            3'b100:  return 10'h380;
            default: return 10'h000;
        endcase
    endfunction

    // Drive one cycle of stimulus, push the expected post-edge outputs, then pop and compare.
    task automatic cyc(input logic ini, input logic [2:0] conf, input logic lst,
                       input logic [9:0] ecs, input logic [1:0] eidx,
                       input logic eocu, input logic efin, input logic eerr);
        exp_t e;
        @(negedge clk);
        inicio = ini;
        funcion_conf = conf;
        listo = lst;
        sb.push_back('{cs: ecs, indice: eidx, ocupado: eocu, fin: efin, error: eerr, cs_leg: leg_mask(conf)});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_val("cs", 32'(cs_s), 32'(e.cs));
        check_val("indice", 32'(indice_s), 32'(e.indice));
        check_val("ocupado", 32'(ocupado_s), 32'(e.ocupado));
        check_val("fin", 32'(fin_s), 32'(e.fin));
        check_val("error", 32'(error_s), 32'(e.error));
        check_val("leg_cs", 32'(cs_l), 32'(e.cs_leg));
        check_val("leg_flags", {29'd0, ocupado_l, fin_l, error_l}, 32'd0);
        check_val("leg_indice", 32'(indice_l), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_seq"}, {17'd0, cs_s, indice_s, ocupado_s, fin_s, error_s}, 32'd0);
        check_val({tag, "_leg"}, {17'd0, cs_l, indice_l, ocupado_l, fin_l, error_l}, 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // hora walk; a second inicio mid-walk is ignored
        cyc(1, 3'b001, 0, 10'h001, 2'd0, 1, 0, 0);
        cyc(0, 3'b001, 1, 10'h000, 2'd0, 1, 0, 0);
        cyc(1, 3'b100, 0, 10'h002, 2'd1, 1, 0, 0);
        cyc(0, 3'b001, 1, 10'h000, 2'd1, 1, 0, 0);
        cyc(0, 3'b001, 0, 10'h004, 2'd2, 1, 0, 0);
        cyc(0, 3'b001, 1, 10'h000, 2'd2, 1, 1, 0);
        cyc(0, 3'b001, 0, 10'h000, 2'd0, 0, 0, 0);

        // fecha walk; funcion_conf switched to timer after the latch
        cyc(1, 3'b010, 0, 10'h008, 2'd0, 1, 0, 0);
        cyc(0, 3'b100, 1, 10'h000, 2'd0, 1, 0, 0);
        cyc(0, 3'b100, 0, 10'h010, 2'd1, 1, 0, 0);
        cyc(0, 3'b100, 1, 10'h000, 2'd1, 1, 0, 0);
        cyc(0, 3'b100, 0, 10'h020, 2'd2, 1, 0, 0);
        cyc(0, 3'b100, 1, 10'h000, 2'd2, 1, 0, 0);
        cyc(0, 3'b100, 0, 10'h040, 2'd3, 1, 0, 0);
        cyc(0, 3'b100, 1, 10'h000, 2'd3, 1, 1, 0);
        // inicio during FIN ignored, accepted on the following edge
        cyc(1, 3'b001, 0, 10'h000, 2'd0, 0, 0, 0);
        cyc(1, 3'b001, 0, 10'h001, 2'd0, 1, 0, 0);
        cyc(0, 3'b001, 1, 10'h000, 2'd0, 1, 0, 0);
        cyc(0, 3'b001, 1, 10'h002, 2'd1, 1, 0, 0);
        cyc(0, 3'b001, 1, 10'h000, 2'd1, 1, 0, 0);
        cyc(0, 3'b001, 1, 10'h004, 2'd2, 1, 0, 0);
        cyc(0, 3'b001, 1, 10'h000, 2'd2, 1, 1, 0);
        cyc(0, 3'b001, 1, 10'h000, 2'd0, 0, 0, 0);

        // invalid codes
        cyc(1, 3'b011, 0, 10'h000, 2'd0, 0, 0, 1);
        cyc(0, 3'b011, 0, 10'h000, 2'd0, 0, 0, 0);
        cyc(1, 3'b111, 0, 10'h000, 2'd0, 0, 0, 1);
        cyc(1, 3'b000, 0, 10'h000, 2'd0, 0, 0, 1);
        cyc(0, 3'b000, 1, 10'h000, 2'd0, 0, 0, 0);

        // timer with listo withheld: 8 cycles of cs then error
        cyc(1, 3'b100, 0, 10'h080, 2'd0, 1, 0, 0);
        for (int i = 2; i <= 8; i++) cyc(0, 3'b100, 0, 10'h080, 2'd0, 1, 0, 0);
        cyc(0, 3'b100, 0, 10'h000, 2'd0, 0, 0, 1);
        cyc(0, 3'b100, 0, 10'h000, 2'd0, 0, 0, 0);

        // listo at the last allowed cycle wins over timeout; held listo through the rest
        cyc(1, 3'b100, 0, 10'h080, 2'd0, 1, 0, 0);
        for (int i = 2; i <= 8; i++) cyc(0, 3'b100, 0, 10'h080, 2'd0, 1, 0, 0);
        cyc(0, 3'b100, 1, 10'h000, 2'd0, 1, 0, 0);
        cyc(0, 3'b100, 0, 10'h100, 2'd1, 1, 0, 0);
        cyc(0, 3'b100, 1, 10'h000, 2'd1, 1, 0, 0);
        cyc(0, 3'b100, 1, 10'h200, 2'd2, 1, 0, 0);
        cyc(0, 3'b100, 1, 10'h000, 2'd2, 1, 1, 0);
        cyc(0, 3'b100, 0, 10'h000, 2'd0, 0, 0, 0);

        // asynchronous reset mid fecha walk at indice 2
        cyc(1, 3'b010, 0, 10'h008, 2'd0, 1, 0, 0);
        cyc(0, 3'b010, 1, 10'h000, 2'd0, 1, 0, 0);
        cyc(0, 3'b010, 0, 10'h010, 2'd1, 1, 0, 0);
        cyc(0, 3'b010, 1, 10'h000, 2'd1, 1, 0, 0);
        cyc(0, 3'b010, 0, 10'h020, 2'd2, 1, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        cyc(0, 3'b010, 1, 10'h000, 2'd0, 0, 0, 0);
        cyc(0, 3'b010, 1, 10'h000, 2'd0, 0, 0, 0);

        check_val("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
